// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and default widths for the RAM arbiter
package ram_arb_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {INIT, IDLE} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;
endpackage

// File: rtl/ram_arb_if.sv
// rtl/ram_arb_if.sv - two-requester access bus between clients and the RAM arbiter
interface ram_arb_if import ram_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_din;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_dout;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_din;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_dout;

  modport slave (
    input  a_req, a_we, a_addr, a_din, b_req, b_we, b_addr, b_din,
    output a_gnt, a_rvalid, a_dout, b_gnt, b_rvalid, b_dout
  );

  modport master (
    output a_req, a_we, a_addr, a_din, b_req, b_we, b_addr, b_din,
    input  a_gnt, a_rvalid, a_dout, b_gnt, b_rvalid, b_dout
  );
endinterface

// File: rtl/ram_arb_rr.sv
// rtl/ram_arb_rr.sv - two-way round-robin pick with priority pointer
module ram_arb_rr import ram_arb_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);
  port_t prio;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    a_gnt = en & a_req & (~b_req | (prio == PORT_A));
    b_gnt = en & b_req & (~a_req | (prio == PORT_B));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio <= PORT_A;
    end else if (a_gnt) begin
      prio <= PORT_B;
    end else if (b_gnt) begin
      prio <= PORT_A;
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter onto a single-port synchronous RAM
// Optional power-up clear sweep enabled by RAM_ARB_INIT_EN.
module ram_arbiter import ram_arb_pkg::*; #(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  ram_arb_if.slave          bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              init_done
);
  logic              a_gnt;
  logic              b_gnt;
  logic              sweep;
  logic [ADDR_W-1:0] sweep_addr;
  logic              rd1_v;
  logic              rd2_v;
  port_t             rd1_port;
  port_t             rd2_port;

  ram_arb_rr u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (init_done),
    .a_req (bus.a_req),
    .b_req (bus.b_req),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  assign bus.a_gnt = a_gnt;
  assign bus.b_gnt = b_gnt;

`ifdef RAM_ARB_INIT_EN
  state_t            state;
  logic [ADDR_W-1:0] init_cnt;

  // Counter stops at the top address instead of wrapping back into the sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          if (init_cnt == {ADDR_W{1'b1}}) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        IDLE: state <= IDLE;
      endcase
    end
  end

  assign sweep      = (state == INIT);
  assign sweep_addr = init_cnt;
`else
  assign init_done  = rst;
  assign sweep      = 1'b0;
  assign sweep_addr = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
    end else if (sweep) begin
      ram_addr <= sweep_addr;
      ram_din  <= INIT_VAL;
      ram_we   <= 1'b1;
    end else if (a_gnt) begin
      ram_addr <= bus.a_addr;
      ram_din  <= bus.a_din;
      ram_we   <= bus.a_we;
    end else if (b_gnt) begin
      ram_addr <= bus.b_addr;
      ram_din  <= bus.b_din;
      ram_we   <= bus.b_we;
    end else begin
      ram_we <= 1'b0;
    end
  end

  // Two-stage tag pipe: command register, then RAM output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd1_v        <= 1'b0;
      rd2_v        <= 1'b0;
      rd1_port     <= PORT_A;
      rd2_port     <= PORT_A;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      bus.a_dout   <= '0;
      bus.b_dout   <= '0;
    end else begin
      rd1_v        <= (a_gnt & ~bus.a_we) | (b_gnt & ~bus.b_we);
      rd1_port     <= b_gnt ? PORT_B : PORT_A;
      rd2_v        <= rd1_v;
      rd2_port     <= rd1_port;
      bus.a_rvalid <= rd2_v & (rd2_port == PORT_A);
      bus.b_rvalid <= rd2_v & (rd2_port == PORT_B);
      if (rd2_v && rd2_port == PORT_A) bus.a_dout <= ram_dout;
      if (rd2_v && rd2_port == PORT_B) bus.b_dout <= ram_dout;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter (RAM_ARB_INIT_EN optional)
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int             AW = 8;
  localparam int             DW = 8;
  localparam logic [DW-1:0]  IV = 8'hA5;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } req_t;

  typedef struct {
    int            n;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } cmd_t;

  typedef struct {
    int            due;
    port_t         port;
    logic [DW-1:0] data;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_we;
  logic          init_done;

  ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_VAL(IV)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int            checks = 0;
  int            passed = 0;
  int            ecnt = 0;
  logic [DW-1:0] shadow [2**AW];
  port_t         last_win = PORT_B;
  cmd_t          cmd_q[$];
  rd_t           rd_q[$];
  req_t          a_script[$];
  req_t          b_script[$];
  req_t          a_cur;
  req_t          b_cur;
  bit            rand_mode = 1'b0;
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  bit            prev_done = 1'b0;
  cmd_t          mc;
  rd_t           mr;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.we   = 1'($urandom_range(1));
    r.addr = AW'($urandom_range(17));
    r.din  = DW'($urandom_range(255));
    return r;
  endfunction

  task automatic load(input port_t p);
    req_t r;
    bit   go;
    r  = '{1'b0, '0, '0};
    go = 1'b0;
    if (p == PORT_A && a_script.size() > 0) begin
      r = a_script.pop_front(); go = 1'b1;
    end else if (p == PORT_B && b_script.size() > 0) begin
      r = b_script.pop_front(); go = 1'b1;
    end else if (rand_mode && $urandom_range(99) < 70) begin
      r = rand_req(); go = 1'b1;
    end
    if (p == PORT_A) begin
      a_cur = r; bus.a_req = go; bus.a_we = r.we; bus.a_addr = r.addr; bus.a_din = r.din;
    end else begin
      b_cur = r; bus.b_req = go; bus.b_we = r.we; bus.b_addr = r.addr; bus.b_din = r.din;
    end
  endtask

  // Reference: transfers take effect in grant order against a flat shadow memory.
  task automatic model_xfer(input port_t p, input req_t r);
    int n;
    n        = ecnt + 1;
    last_win = p;
    cmd_q.push_back('{n, r.we, r.addr, r.din});
    if (r.we) shadow[r.addr] = r.din;
    else rd_q.push_back('{n + 2, p, shadow[r.addr]});
  endtask

  task automatic step();
    bit ga;
    bit gb;
    @(negedge clk);
    ga = bus.a_req && (!bus.b_req || last_win == PORT_B);
    gb = bus.b_req && (!bus.a_req || last_win == PORT_A);
    check("a_gnt", 32'(bus.a_gnt), 32'(ga));
    check("b_gnt", 32'(bus.b_gnt), 32'(gb));
    if (ga) model_xfer(PORT_A, a_cur);
    else if (gb) model_xfer(PORT_B, b_cur);
    @(posedge clk);
    #1;
    if (ga || !bus.a_req) load(PORT_A);
    if (gb || !bus.b_req) load(PORT_B);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((bus.a_req || bus.b_req || a_script.size() > 0 || b_script.size() > 0) && guard < 300) begin
      step();
      guard++;
    end
    if (guard >= 300) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_init();
`ifdef RAM_ARB_INIT_EN
    int wr;
    int bad;
    int gbad;
    int cyc;
    wr = 0; bad = 0; gbad = 0; cyc = 0;
    forever begin
      @(negedge clk);
      if (bus.a_gnt || bus.b_gnt) gbad++;
      if (ram_we) begin
        if (ram_addr !== AW'(wr) || ram_din !== IV) bad++;
        wr++;
      end
      cyc++;
      if (init_done || cyc > 400) break;
    end
    check("init_timeout", 32'(cyc > 400), 32'd0);
    check("init_writes", 32'(wr), 32'd256);
    check("init_order", 32'(bad), 32'd0);
    check("init_gnt_low", 32'(gbad), 32'd0);
    for (int i = 0; i < 2**AW; i++) shadow[i] = IV;
    @(posedge clk);
    #1;
`else
    check("init_done_now", 32'(init_done), 32'd1);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_a_gnt"}, 32'(bus.a_gnt), 32'd0);
    check({tag, "_b_gnt"}, 32'(bus.b_gnt), 32'd0);
    check({tag, "_rvalid"}, 32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);
    check({tag, "_dout"}, 32'({bus.a_dout, bus.b_dout}), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_din"}, 32'(ram_din), 32'd0);
    check({tag, "_init_done"}, 32'(init_done), 32'd0);
  endtask

  // Monitor: compares RAM commands and read returns against the queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        if (cmd_q.size() > 0 && cmd_q[0].n == ecnt) begin
          mc = cmd_q.pop_front();
          check("ram_we", 32'(ram_we), 32'(mc.we));
          check("ram_addr", 32'(ram_addr), 32'(mc.addr));
          if (mc.we) check("ram_din", 32'(ram_din), 32'(mc.din));
        end else begin
          check("ram_we_idle", 32'(ram_we), 32'd0);
        end
      end
      prev_done = init_done;
      if (bus.a_rvalid || bus.b_rvalid) begin
        check("rvalid_both", 32'(bus.a_rvalid && bus.b_rvalid), 32'd0);
        if (rd_q.size() == 0) begin
          check("rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          mr = rd_q.pop_front();
          check("rd_port", 32'(bus.b_rvalid), 32'(mr.port == PORT_B));
          check("rd_latency", 32'(ecnt), 32'(mr.due));
          if (bus.a_rvalid) begin
            check("a_dout", 32'(bus.a_dout), 32'(mr.data));
            check("b_dout_hold", 32'(bus.b_dout), 32'(last_b));
            last_a = bus.a_dout;
          end else begin
            check("b_dout", 32'(bus.b_dout), 32'(mr.data));
            check("a_dout_hold", 32'(bus.a_dout), 32'(last_a));
            last_b = bus.b_dout;
          end
        end
      end else begin
        while (rd_q.size() > 0 && rd_q[0].due <= ecnt) begin
          mr = rd_q.pop_front();
          check("rvalid_missing", 32'd0, 32'd1);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    a_cur = '{1'b0, '0, '0};
    b_cur = '{1'b0, '0, '0};
    load(PORT_A);
    load(PORT_B);
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;
    wait_init();

    // A alone writes 0..7 back-to-back
    for (int i = 0; i < 8; i++) a_script.push_back('{1'b1, AW'(i), DW'(i * 3)});
    load(PORT_A);
    drain();

    // B writes addr 8, A reads it on the following cycle
    b_script.push_back('{1'b1, AW'(8), DW'(40)});
    load(PORT_B);
    a_script.push_back('{1'b0, AW'(8), '0});
    a_script.push_back('{1'b0, AW'(16), '0});
    step();
    drain();

    // both ports read continuously
    for (int i = 0; i < 8; i++) begin
      a_script.push_back('{1'b0, AW'(i), '0});
      b_script.push_back('{1'b0, AW'(7 - i), '0});
    end
    load(PORT_A);
    load(PORT_B);
    drain();

    rand_mode = 1'b1;
    repeat (500) step();
    rand_mode = 1'b0;
    drain();
    repeat (4) @(negedge clk);

    // reset with a read being accepted
    a_cur = '{1'b0, AW'(3), '0};
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = AW'(3); bus.a_din = '0;
    @(negedge clk);
    check("rst_pre_gnt", 32'(bus.a_gnt), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    b_cur = '{1'b0, AW'(5), '0};
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = AW'(5); bus.b_din = '0;
    #1;
    check_reset_vals("midrst");
    cmd_q.delete();
    rd_q.delete();
    last_a   = '0;
    last_b   = '0;
    last_win = PORT_B;
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_init();
    step();
    rand_mode = 1'b1;
    repeat (100) step();
    rand_mode = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    check("rd_drain", 32'(rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter INIT_VAL, default 0, word written during init sweep.
REQ-004 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports a_req/b_req  in  1  access request per requester.
REQ-007 SHALL have ports a_we/b_we  in  1  1=write, 0=read, qualified by req.
REQ-008 SHALL have ports a_addr/b_addr  in  ADDR_W  request address.
REQ-009 SHALL have ports a_din/b_din  in  DATA_W  write data.
REQ-010 SHALL have ports a_gnt/b_gnt  out  1  request accepted this cycle (combinational).
REQ-011 SHALL have ports a_rvalid/b_rvalid  out  1  one-cycle read-data-valid pulse.
REQ-012 SHALL have ports a_dout/b_dout  out  DATA_W  read data, valid when rvalid.
REQ-013 SHALL have ports ram_addr  out  ADDR_W, ram_din  out  DATA_W, ram_we  out  1: registered single-port RAM command.
REQ-014 SHALL have port ram_dout  in  DATA_W  RAM read data, valid one cycle after command.
REQ-015 SHALL have port init_done  out  1  high when arbiter serves requests.

Function
REQ-016 Transfer occurs on a rising edge where x_req and x_gnt are both high; at most one transfer per cycle.
REQ-017 Requester SHALL hold req/we/addr/din stable until gnt; block may rely on this.
REQ-018 Single requester: gnt same cycle, every cycle (back-to-back, no bubbles).
REQ-019 Both requesting: grant the port that did not win the previous contested-or-uncontested transfer (round-robin pointer updated on every transfer); after reset pointer favours A.
REQ-020 gnt SHALL be low for both ports while init_done=0.
REQ-021 On transfer, ram_addr/ram_din/ram_we register the winner's command; ram_we=0 in cycles without a write transfer.
REQ-022 Read latency: request accepted at edge k -> x_rvalid high for exactly the cycle after edge k+2, x_dout = ram_dout at that point (captured).
REQ-023 Write followed next cycle by read of same address (any ports) SHALL return new data.
REQ-024 rvalid of the non-reading port SHALL stay low; dout holds its last value.
REQ-025 Address arithmetic: init sweep counter wraps at 2^ADDR_W-1 and terminates there, no overflow into done logic.

Reset
REQ-026 During rst=0: gnt=0, rvalid=0, dout=0, ram_we=0, ram_addr=0, ram_din=0, pointer=A, read pipeline flushed.
REQ-027 Reset mid-operation SHALL drop in-flight reads (no rvalid after release) and restart init sweep from address 0.

Configuration
REQ-028 Macro RAM_ARB_INIT_EN defined: FSM INIT->IDLE; INIT writes INIT_VAL to addresses 0..2^ADDR_W-1, one per cycle, starting first edge after reset release; init_done rises the cycle after last write.
REQ-029 Macro undefined: no INIT state or sweep counter; init_done=1 constantly outside reset; first request served on first edge after release.

Structure
REQ-030 Package ram_arb_pkg SHALL hold state enum (INIT, IDLE), port-id typedef (PORT_A, PORT_B), default ADDR_W/DATA_W constants.
REQ-031 Sub-module ram_arb_rr SHALL implement the 2-way round-robin pick and pointer; all else in ram_arbiter.

Verification
REQ-032 A only, writes addr 0..7 data i*3 back-to-back -> a_gnt high 8 consecutive cycles, ram_we high 8 cycles, addresses 0..7 in order.
REQ-033 A and B both read continuously -> grants alternate A,B,A,B; each port gets 1 rvalid per 2 cycles, latency 2 cycles.
REQ-034 B writes addr 8 data 40, next cycle A reads addr 8 -> a_rvalid with a_dout=40, b_rvalid never high.
REQ-035 With RAM_ARB_INIT_EN, INIT_VAL=0xA5 -> gnt low 256 cycles, 256 writes 0x00..0xFF, init_done rises; read of 0x10 returns 0xA5.
REQ-036 Assert rst for one cycle with a read in flight -> no rvalid afterwards, all outputs at reset values, init sweep restarts at 0 when macro defined.
